sdft_sequencer: RTL and testbench

- Initiator that drives the sliding-DFT engine's control and read ports.
- Forwards each incoming ADC sample into the engine with a one-cycle start pulse when the engine is ready.
- Every LINE_DECIM samples, sweeps bins 0..LIMIT_BINS-1 through the engine's read port and emits one magnitude line as a valid/ready stream to the waterfall line writer.
- Handles engine read latency, output backpressure and sample overrun.

---
 rtl/sdft_pkg.sv | 28 ++
 rtl/sdft_line_fifo.sv | 50 +++++
 rtl/sdft_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_sdft_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdft_pkg.sv
// Shared definitions for the sliding-DFT sequencer: FSM states, default bin count, log-compress mapping.
package sdft_pkg;

    localparam int SDFT_LIMIT_BINS = 32;
    localparam int BIN_ADDR_W      = $clog2(SDFT_LIMIT_BINS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BUSY,
        ST_RD_REQ,
        ST_SWEEP,
        ST_DRAIN
    } sdft_state_t;

    // {msb index, four bits below the msb left-aligned}; 0 and 1 both map to 0.
    function automatic logic [7:0] log_compress(input logic [15:0] v);
        logic [3:0]  msb;
        logic [15:0] norm;
        msb = 4'd0;
        for (int i = 1; i < 16; i++) begin
            if (v[i]) msb = 4'(i);
        end
        norm = v << (4'd15 - msb);
        return {msb, norm[14:11]};
    endfunction

endpackage

// File: rtl/sdft_line_fifo.sv
// Synchronous FIFO carrying line beats to the waterfall writer.
// Latency: a pushed entry is visible at the head on the following cycle.
// Backpressure: push is ignored when full, pop is ignored when empty.
module sdft_line_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_dat,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_dat,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/sdft_sequencer.sv
// Feeds ADC samples into the sliding-DFT engine and sweeps its bins into a magnitude line stream; LOG_COMPRESS_EN selects log-compressed magnitudes.
// Latency: start one cycle after the engine is idle with a sample pending; a line sweep takes LIMIT_BINS+READ_LAT+1 cycles unstalled.
// Backpressure: line_ready low stalls bin reads so the line FIFO never overflows; a sample arriving while the slot is full is dropped and counted.
module sdft_sequencer
    import sdft_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FREQ_W     = 16,
    parameter int LIMIT_BINS = SDFT_LIMIT_BINS,
    parameter int LINE_DECIM = 64,
    parameter int READ_LAT   = 2,
    parameter int OVR_W      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             sample_in,
    input  logic                          sample_valid,
    output logic [DATA_W-1:0]             sdft_sample,
    output logic                          sdft_start,
    output logic                          sdft_read,
    output logic [$clog2(LIMIT_BINS)-1:0] sdft_bin_addr,
    input  logic [FREQ_W-1:0]             sdft_bin_out,
    input  logic                          sdft_ready,
    output logic [FREQ_W-1:0]             line_data,
    output logic [$clog2(LIMIT_BINS)-1:0] line_addr,
    output logic                          line_last,
    output logic                          line_valid,
    input  logic                          line_ready,
    output logic [OVR_W-1:0]              overrun_cnt
);
    localparam int AW         = $clog2(LIMIT_BINS);
    localparam int DW         = (LINE_DECIM > 1) ? $clog2(LINE_DECIM) : 1;
    localparam int FIFO_DEPTH = READ_LAT + 2;
    localparam int FIFO_W     = FREQ_W + AW + 1;
    localparam int CW         = $clog2(FIFO_DEPTH + 1);

    sdft_state_t         state;
    sdft_state_t         state_d;
    logic                slot_full;
    logic [DATA_W-1:0]   slot_dat;
    logic [DW-1:0]       dec_cnt;
    logic                line_owed;
    logic                seen_low;
    logic [AW-1:0]       rd_addr;
    logic [AW-1:0]       cap_addr;
    logic [READ_LAT-1:0] tag;
    logic                do_start;
    logic                busy_done;
    logic                issue;
    logic                drain_done;
    logic                push;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CW-1:0]       fifo_count;
    logic [FIFO_W-1:0]   push_dat;
    logic [FIFO_W-1:0]   pop_dat;
    logic [FREQ_W-1:0]   cap_val;

    always_comb begin
        state_d    = state;
        do_start   = 1'b0;
        busy_done  = 1'b0;
        issue      = 1'b0;
        drain_done = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (slot_full && sdft_ready) begin
                    do_start = 1'b1;
                    state_d  = ST_START;
                end else if (line_owed && sdft_ready) begin
                    state_d = ST_RD_REQ;
                end
            end
            ST_START: state_d = ST_BUSY;
            ST_BUSY: begin
                if (seen_low && sdft_ready) begin
                    busy_done = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_RD_REQ: state_d = ST_SWEEP;
            ST_SWEEP: begin
                // Only advance when every outstanding read plus this one is guaranteed a FIFO slot.
                issue = (int'(FIFO_DEPTH) - int'(fifo_count)) > $countones(tag);
                if (issue && rd_addr == AW'(LIMIT_BINS - 1)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Leave on the cycle the final result is captured.
                if ($countones(tag) == int'(tag[READ_LAT-1])) begin
                    drain_done = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            slot_full   <= 1'b0;
            slot_dat    <= '0;
            sdft_sample <= '0;
            dec_cnt     <= '0;
            line_owed   <= 1'b0;
            seen_low    <= 1'b0;
            rd_addr     <= '0;
            cap_addr    <= '0;
            tag         <= '0;
            overrun_cnt <= '0;
        end else begin
            state <= state_d;

            if (sample_valid) begin
                if (!slot_full || do_start) begin
                    slot_full <= 1'b1;
                    slot_dat  <= sample_in;
                end else if (overrun_cnt != '1) begin
                    overrun_cnt <= overrun_cnt + 1'b1;
                end
            end else if (do_start) begin
                slot_full <= 1'b0;
            end
            if (do_start) sdft_sample <= slot_dat;

            if (state == ST_BUSY && !sdft_ready) seen_low <= 1'b1;
            if (busy_done) begin
                seen_low <= 1'b0;
                if (dec_cnt == DW'(LINE_DECIM - 1)) begin
                    dec_cnt   <= '0;
                    line_owed <= 1'b1;
                end else begin
                    dec_cnt <= dec_cnt + 1'b1;
                end
            end
            if (drain_done) line_owed <= 1'b0;

            if (state == ST_IDLE && state_d == ST_RD_REQ) begin
                rd_addr  <= '0;
                cap_addr <= '0;
            end else begin
                if (issue) rd_addr <= rd_addr + 1'b1;
                if (tag[READ_LAT-1]) cap_addr <= cap_addr + 1'b1;
            end
            tag <= (tag << 1) | READ_LAT'(issue);
        end
    end

`ifdef LOG_COMPRESS_EN
    assign cap_val = FREQ_W'(log_compress(16'(sdft_bin_out)));
`else
    assign cap_val = sdft_bin_out;
`endif

    assign push     = tag[READ_LAT-1];
    assign push_dat = {cap_val, cap_addr, cap_addr == AW'(LIMIT_BINS - 1)};

    sdft_line_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_line_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (pop_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign sdft_start    = (state == ST_START);
    assign sdft_read     = (state == ST_RD_REQ) || (state == ST_SWEEP);
    assign sdft_bin_addr = rd_addr;
    assign line_valid    = !fifo_empty;
    assign pop           = line_valid && line_ready;
    assign {line_data, line_addr, line_last} = fifo_empty ? '0 : pop_dat;

endmodule

// File: tb/tb_sdft_sequencer.sv
// Scoreboard bench for sdft_sequencer with a behavioural engine model; expected starts and line beats
// are queued at stimulus time and popped by a monitor whenever the DUT presents them.
module tb_sdft_sequencer;
    localparam int DECIM = 4;
    localparam int LB    = 32;
    localparam int AW    = sdft_pkg::BIN_ADDR_W;

    typedef struct packed {
        logic [15:0]   d;
        logic [AW-1:0] a;
        logic          l;
    } beat_t;

    logic          clk;
    logic          reset;
    logic [7:0]    sample_in;
    logic          sample_valid;
    logic [7:0]    sdft_sample;
    logic          sdft_start;
    logic          sdft_read;
    logic [AW-1:0] sdft_bin_addr;
    logic [15:0]   sdft_bin_out;
    logic          sdft_ready;
    logic [15:0]   line_data;
    logic [AW-1:0] line_addr;
    logic          line_last;
    logic          line_valid;
    logic          line_ready;
    logic [7:0]    overrun_cnt;

    int          checks = 0;
    int          errors = 0;
    int          proc_cnt = 0;
    int          read_cycles = 0;
    int          rdy_mode = 0;
    bit          eng_hold = 0;
    logic [15:0] eng_tab [LB];
    logic [7:0]  exp_start[$];
    beat_t       exp_beat[$];

    sdft_sequencer #(.LINE_DECIM(DECIM)) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .sdft_sample   (sdft_sample),
        .sdft_start    (sdft_start),
        .sdft_read     (sdft_read),
        .sdft_bin_addr (sdft_bin_addr),
        .sdft_bin_out  (sdft_bin_out),
        .sdft_ready    (sdft_ready),
        .line_data     (line_data),
        .line_addr     (line_addr),
        .line_last     (line_last),
        .line_valid    (line_valid),
        .line_ready    (line_ready),
        .overrun_cnt   (overrun_cnt)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d checks %0d errors so far", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference magnitude mapping computed arithmetically from the line format rules.
    function automatic logic [15:0] ref_val(input logic [15:0] v);
`ifdef LOG_COMPRESS_EN
        int e;
        int m;
        if (v < 16'd2) return 16'd0;
        e = 0;
        while ((int'(v) >> (e + 1)) != 0) e++;
        m = ((int'(v) * 16) >> e) % 16;
        return 16'(e * 16 + m);
`else
        return v;
`endif
    endfunction

    // Engine: busy 4 cycles after a start, bin_out follows the address with 2 cycles latency.
    initial begin
        int          eng_busy;
        bit          st;
        logic [AW-1:0] a_now, a_p1, a_p2;
        eng_busy = 0; a_p1 = '0; a_p2 = '0;
        sdft_ready = 1'b1;
        sdft_bin_out = '0;
        forever begin
            @(negedge clk);
            st = sdft_start;
            a_now = sdft_bin_addr;
            @(posedge clk); #1;
            if (st) eng_busy = 4;
            else if (eng_busy > 0) eng_busy--;
            a_p2 = a_p1;
            a_p1 = a_now;
            sdft_ready = (eng_busy == 0) && !eng_hold;
            sdft_bin_out = eng_tab[a_p2];
        end
    end

    initial begin
        int ph;
        ph = 0;
        line_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       line_ready = 1'b1;
                1:       line_ready = (ph % 4 == 0);
                2:       line_ready = 1'($urandom_range(0, 1));
                default: line_ready = 1'b0;
            endcase
            ph++;
        end
    end

    // Monitor: pops expectations on every start pulse and every transferred beat.
    bit    prev_stall = 0;
    beat_t prev_beat;
    always @(negedge clk) begin
        beat_t cur;
        cur = {line_data, line_addr, line_last};
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (sdft_start) begin
                check("start_while_ready", {31'd0, sdft_ready}, 32'd1);
                check("start_and_read", {31'd0, sdft_read}, 32'd0);
                if (exp_start.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL start_unexpected: sample 0x%0h, none expected", sdft_sample);
                end else begin
                    check("start_sample", 32'(sdft_sample), 32'(exp_start.pop_front()));
                end
            end
            if (sdft_read) read_cycles++;
            if (prev_stall) begin
                check("hold_valid", {31'd0, line_valid}, 32'd1);
                check("hold_beat", 32'(cur), 32'(prev_beat));
            end
            if (line_valid && line_ready) begin
                if (exp_beat.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL beat_unexpected: got beat 0x%0h, none expected", cur);
                end else begin
                    check("beat", 32'(cur), 32'(exp_beat.pop_front()));
                end
            end
            prev_stall = line_valid && !line_ready;
            prev_beat = cur;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_line();
        beat_t b;
        for (int i = 0; i < LB; i++) begin
            b.d = ref_val(eng_tab[i]);
            b.a = AW'(i);
            b.l = (i == LB - 1);
            exp_beat.push_back(b);
        end
    endtask

    task automatic send_sample(input logic [7:0] v, input bit accept);
        @(posedge clk); #1;
        sample_in = v;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        if (accept) begin
            exp_start.push_back(v);
            proc_cnt++;
            if (proc_cnt % DECIM == 0) push_line();
        end
    endtask

    task automatic send_group(input int gap);
        for (int k = 0; k < DECIM; k++) begin
            send_sample(8'($urandom), 1'b1);
            idle(gap);
        end
    endtask

    task automatic wait_lines_done(input int budget);
        int n;
        n = 0;
        while (exp_beat.size() != 0 && n < budget) begin
            @(posedge clk); n++;
        end
        #1;
        checks++;
        if (exp_beat.size() != 0) begin
            errors++;
            $display("FAIL line_complete: %0d beats still outstanding after %0d cycles", exp_beat.size(), budget);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < LB; i++) eng_tab[i] = 16'($urandom);
    endtask

    initial begin
        int gaps;
        int n;
        reset = 1'b1;
        sample_in = '0;
        sample_valid = 1'b0;
        for (int i = 0; i < LB; i++) eng_tab[i] = 16'(100 + i);
        repeat (3) @(posedge clk);
        #1;
        check("rst_start", {31'd0, sdft_start}, 32'd0);
        check("rst_read", {31'd0, sdft_read}, 32'd0);
        check("rst_bin_addr", 32'(sdft_bin_addr), 32'd0);
        check("rst_sample", 32'(sdft_sample), 32'd0);
        check("rst_line_valid", {31'd0, line_valid}, 32'd0);
        check("rst_line_data", 32'(line_data), 32'd0);
        check("rst_line_addr", 32'(line_addr), 32'd0);
        check("rst_line_last", {31'd0, line_last}, 32'd0);
        check("rst_overrun", 32'(overrun_cnt), 32'd0);
        reset = 1'b0;

        // Line 1: bins 100+addr, sink always ready, beats must be back to back.
        rdy_mode = 0;
        read_cycles = 0;
        for (int k = 0; k < DECIM; k++) begin
            send_sample(8'($urandom), 1'b1);
            if (k < DECIM - 1) idle(20);
        end
        n = 0;
        while (!line_valid && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("first_beat_seen", {31'd0, line_valid}, 32'd1);
        gaps = 0;
        for (int i = 0; i < LB; i++) begin
            if (!line_valid) gaps++;
            @(posedge clk); #1;
        end
        check("line_gaps", 32'(gaps), 32'd0);
        wait_lines_done(500);
        check("read_cycles", 32'(read_cycles), 32'(LB + 1));

        // Line 2: sink ready one cycle in four.
        fill_random();
`ifdef LOG_COMPRESS_EN
        eng_tab[0] = 16'h0100;
        eng_tab[1] = 16'h00F0;
        eng_tab[2] = 16'h0000;
        eng_tab[3] = 16'h0001;
`endif
        rdy_mode = 1;
        send_group(20);
        wait_lines_done(2000);

        // Overrun: third strobe lands while the slot already holds a sample.
        rdy_mode = 0;
        idle(20);
        send_sample(8'($urandom), 1'b1);
        send_sample(8'($urandom), 1'b1);
        send_sample(8'($urandom), 1'b0);
        check("overrun_one", 32'(overrun_cnt), 32'd1);
        idle(20);
        eng_hold = 1'b1;
        idle(3);
        send_sample(8'($urandom), 1'b1);
        for (int i = 0; i < 300; i++) send_sample(8'($urandom), 1'b0);
        check("overrun_sat", 32'(overrun_cnt), 32'd255);
        eng_hold = 1'b0;
        fill_random();
        rdy_mode = 2;
        idle(20);
        send_sample(8'($urandom), 1'b1);
        wait_lines_done(2000);
        check("overrun_hold", 32'(overrun_cnt), 32'd255);

        // Random lines with random sink readiness.
        for (int g = 0; g < 2; g++) begin
            fill_random();
            rdy_mode = 2;
            send_group(15);
            wait_lines_done(2000);
        end

        // Reset in the middle of a stalled sweep.
        fill_random();
        rdy_mode = 3;
        send_group(20);
        n = 0;
        while (!sdft_read && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("sweep_entered", {31'd0, sdft_read}, 32'd1);
        idle(10);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_read", {31'd0, sdft_read}, 32'd0);
        check("midrst_start", {31'd0, sdft_start}, 32'd0);
        check("midrst_line_valid", {31'd0, line_valid}, 32'd0);
        check("midrst_overrun", 32'(overrun_cnt), 32'd0);
        reset = 1'b0;
        exp_beat.delete();
        proc_cnt = 0;
        rdy_mode = 0;
        fill_random();
        send_group(20);
        wait_lines_done(1000);

        idle(20);
        check("starts_consumed", 32'(exp_start.size()), 32'd0);
        check("beats_consumed", 32'(exp_beat.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
